cross_bar_nxm: RTL and testbench
================================

// Module: cross_bar_nxm
// PURPOSE
//  Parametrised N-master x M-slave crossbar: successor of the fixed 4x4 crossbar. Each master picks a
//  slave from its top address bits; one round-robin arbiter per slave grants at most one master, holds
//  the path for a whole transaction (request, ack, read response) and routes rdata back to the owner.
//  Sits between CPU/DMA masters and memory/peripheral slaves; transactions to different slaves run in parallel.
// PARAMETERS
//  N_MST      4   number of masters (>=2)
//  N_SLV      4   number of slaves (power of two, >=2); SEL_W = $clog2(N_SLV)
//  ADDR_W     32  address width; slave select = addr[ADDR_W-1 -: SEL_W]
//  DATA_W     32  write/read data width
//  TIMEOUT    0   max cycles waiting for ack or resp; 0 disables the watchdog
// PORTS
//  clk          in   1               clock, all logic on rising edge
//  rst_n        in   1               asynchronous active-low reset
//  m_req        in   N_MST           per-master request, held until m_ack
//  m_addr       in   N_MST*ADDR_W    per-master address
//  m_cmd        in   N_MST           1 = write, 0 = read
//  m_wdata      in   N_MST*DATA_W    per-master write data
//  m_ack        out  N_MST           request accepted by the addressed slave
//  m_resp       out  N_MST           read data valid, one-cycle pulse
//  m_rdata      out  N_MST*DATA_W    read data, valid with m_resp
//  m_err        out  N_MST           one-cycle pulse: transaction aborted by the watchdog
//  s_req        out  N_SLV           per-slave request from the granted master
//  s_addr       out  N_SLV*ADDR_W    address forwarded unmodified (select bits kept)
//  s_cmd        out  N_SLV           forwarded command
//  s_wdata      out  N_SLV*DATA_W    forwarded write data
//  s_ack        in   N_SLV           slave accepts request
//  s_resp       in   N_SLV           slave read data valid
//  s_rdata      in   N_SLV*DATA_W    slave read data
// BEHAVIOUR
//  Reset: all outputs 0; every slave FSM in IDLE; every RR pointer = 0 (master 0 has top priority).
//  Per-slave FSM. IDLE: a grant is issued when any master requests this slave.
//    IDLE -> REQ on the edge after the grant. REQ -> IDLE on s_ack&cmd=1. REQ -> RESP on s_ack&cmd=0.
//    RESP -> IDLE on s_resp.
//  Latency: m_req to s_req is one cycle (grant registered). s_ack to m_ack is combinational, same cycle.
//    s_resp/s_rdata to m_resp/m_rdata is combinational, same cycle.
//  In REQ: s_req/s_addr/s_cmd/s_wdata = owner's signals; the other s_* outputs are 0 in IDLE and RESP.
//  RR: search starts at ptr; the first requesting master wins. When a session ends, ptr = owner+1 mod N_MST,
//    so the owner gets lowest priority. ptr does not change while IDLE with no requests.
//  A master that drops m_req while in REQ is a protocol violation. No recovery is defined; the bench asserts
//    against it.
//  Simultaneous events:
//    - Session end and new grant: IDLE->grant can issue on the cycle after RESP/REQ->IDLE; no back-to-back
//      grant in the same cycle. Throughput is one transaction per 2 cycles per slave minimum.
//    - A master requests a slave whose FSM is busy: that master waits; other masters/slaves are unaffected.
//    - s_ack and s_resp asserted in the same cycle in REQ (cmd=0): accepted as a complete read; REQ -> IDLE
//      and m_ack, m_resp pulse together.
//    - s_resp while not in RESP is ignored.
//  Watchdog (TIMEOUT>0): counter cleared on each state entry and increments in REQ/RESP. When it reaches
//    TIMEOUT: m_err pulses to the owner, s_req drops, the FSM goes to IDLE and ptr advances as normal.
//  rst_n asserted mid-transaction: immediate abort. No m_ack/m_resp/m_err is generated for the lost
//    transaction.
//  m_ack/m_resp/m_err for a master come only from the slave it owns. A master owns at most one slave,
//    because its single address selects exactly one slave.
// STRUCTURE
//  Package xbar_pkg: state_e {IDLE,REQ,RESP}, functions sel_of(addr) and rr_pick(req,ptr).
//  Sub-module xbar_slave_port (one per slave, generate loop): request column mask, RR arbiter, FSM,
//    watchdog, registered owner index. The top decodes requests into an N_MST x N_SLV matrix, drives
//    slave-side muxes from each owner index, and ORs the return paths per master.
// TESTING
//  1 M0 reads addr 0x4000_0010 (slave 1), slave acks in cycle 2 and resps 0xDEAD_BEEF in cycle 5
//    -> m_ack[0]=1 in cycle 2; m_rdata[0]=0xDEADBEEF with m_resp[0]; no other slave sees s_req.
//  2 All 4 masters request slave 2 simultaneously, writes, ack in 1 cycle -> grant order M0,M1,M2,M3.
//    M0 re-requests -> granted after M3.
//  3 M0->slave0, M1->slave3 in the same cycle -> both s_req in the next cycle; both complete independently.
//  4 TIMEOUT=8, slave 1 never acks M2 -> m_err[2] pulses 8 cycles after s_req rises; slave 1 returns to IDLE;
//    M3 pending is granted next.
//  5 rst_n low during RESP -> all outputs 0 asynchronously; after release, ptr=0 and a new request is granted
//    normally.
//  6 Parameter sweep N_MST=3, N_SLV=8, ADDR_W=16 random traffic vs. scoreboard -> no lost/duplicated
//    transaction; each slave serves at most one master at a time.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the N x M crossbar.
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Upper bounds for the helper function argument widths.
  localparam int unsigned MAX_MST   = 32;
  localparam int unsigned MAX_IDX_W = 5;
  localparam int unsigned MAX_ADDR  = 64;

  // Slave index taken from the top sel_w bits of an addr_w-wide address.
  function automatic int unsigned sel_of(input logic [MAX_ADDR-1:0] addr,
                                         input int unsigned         addr_w,
                                         input int unsigned         sel_w);
    logic [MAX_ADDR-1:0] sh;
    sh = addr >> (addr_w - sel_w);
    return 32'(sh) & ((32'd1 << sel_w) - 32'd1);
  endfunction

  // Round-robin pick: first requester found searching upward from ptr, wrapping at n.
  function automatic int unsigned rr_pick(input logic [MAX_MST-1:0] req,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned idx;
    int unsigned res;
    logic        found;
    res   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_MST; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && req[idx[MAX_IDX_W-1:0]]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/xbar_slave_port.sv
// Per-slave arbiter: round-robin grant, transaction FSM, watchdog, owner index.
module xbar_slave_port
  import xbar_pkg::*;
#(
  parameter int unsigned N_MST   = 4,
  parameter int unsigned TIMEOUT = 0,
  localparam int unsigned IDX_W  = $clog2(N_MST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_MST-1:0] col_req_i,
  input  logic             owner_cmd_i,
  input  logic             s_ack_i,
  input  logic             s_resp_i,
  output logic             in_req_o,
  output logic             in_resp_o,
  output logic [IDX_W-1:0] owner_o,
  output logic             err_o
);

  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               timeout_c;
  logic [IDX_W-1:0]   nxt_ptr_c;

  // Watchdog fires on the cycle the counter would reach TIMEOUT.
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
  assign nxt_ptr_c = (owner_q == IDX_W'(N_MST - 1)) ? '0 : owner_q + IDX_W'(1);

  // State, owner, pointer, watchdog and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state: grant in IDLE, finish on ack/resp, abort on watchdog expiry.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|col_req_i) begin
          state_d = REQ;
          owner_d = IDX_W'(rr_pick(MAX_MST'(col_req_i), 32'(ptr_q), N_MST));
        end
      end
      REQ: begin
        if (s_ack_i) begin
          cnt_d = '0;
          if (owner_cmd_i || s_resp_i) begin
            state_d = IDLE;
            ptr_d   = nxt_ptr_c;
          end else begin
            state_d = RESP;
          end
        end else if (timeout_c) begin
          state_d = IDLE;
          ptr_d   = nxt_ptr_c;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (s_resp_i) begin
          state_d = IDLE;
          ptr_d   = nxt_ptr_c;
          cnt_d   = '0;
        end else if (timeout_c) begin
          state_d = IDLE;
          ptr_d   = nxt_ptr_c;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_req_o  = (state_q == REQ);
  assign in_resp_o = (state_q == RESP);
  assign owner_o   = owner_q;
  assign err_o     = err_q;

endmodule

// File: rtl/cross_bar_nxm.sv
// N-master x M-slave crossbar with one round-robin arbiter per slave.
module cross_bar_nxm
  import xbar_pkg::*;
#(
  parameter int unsigned N_MST   = 4,
  parameter int unsigned N_SLV   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_MST-1:0]        m_req_i,
  input  logic [N_MST*ADDR_W-1:0] m_addr_i,
  input  logic [N_MST-1:0]        m_cmd_i,
  input  logic [N_MST*DATA_W-1:0] m_wdata_i,
  output logic [N_MST-1:0]        m_ack_o,
  output logic [N_MST-1:0]        m_resp_o,
  output logic [N_MST*DATA_W-1:0] m_rdata_o,
  output logic [N_MST-1:0]        m_err_o,
  output logic [N_SLV-1:0]        s_req_o,
  output logic [N_SLV*ADDR_W-1:0] s_addr_o,
  output logic [N_SLV-1:0]        s_cmd_o,
  output logic [N_SLV*DATA_W-1:0] s_wdata_o,
  input  logic [N_SLV-1:0]        s_ack_i,
  input  logic [N_SLV-1:0]        s_resp_i,
  input  logic [N_SLV*DATA_W-1:0] s_rdata_i
);

  localparam int unsigned SEL_W = $clog2(N_SLV);
  localparam int unsigned IDX_W = $clog2(N_MST);

  logic [SEL_W-1:0] m_sel    [N_MST];
  logic [IDX_W-1:0] owner    [N_SLV];
  logic [N_SLV-1:0] in_req;
  logic [N_SLV-1:0] in_resp;
  logic [N_SLV-1:0] slv_err;
  logic [N_SLV-1:0] own_cmd;

  // Address decode: each master targets exactly one slave.
  for (genvar m = 0; m < N_MST; m++) begin : g_mst
    assign m_sel[m] = SEL_W'(sel_of(MAX_ADDR'(m_addr_i[m*ADDR_W +: ADDR_W]), ADDR_W, SEL_W));
  end

  for (genvar s = 0; s < N_SLV; s++) begin : g_slv
    logic [N_MST-1:0] col_req;

    // Column of the request matrix for this slave.
    always_comb begin
      col_req = '0;
      for (int unsigned m = 0; m < N_MST; m++) begin
        col_req[m] = m_req_i[m] && (m_sel[m] == SEL_W'(s));
      end
    end

    assign own_cmd[s] = m_cmd_i[owner[s]];

    xbar_slave_port #(
      .N_MST   (N_MST),
      .TIMEOUT (TIMEOUT)
    ) u_port (
      .clk         (clk),
      .rst_n       (rst_n),
      .col_req_i   (col_req),
      .owner_cmd_i (own_cmd[s]),
      .s_ack_i     (s_ack_i[s]),
      .s_resp_i    (s_resp_i[s]),
      .in_req_o    (in_req[s]),
      .in_resp_o   (in_resp[s]),
      .owner_o     (owner[s]),
      .err_o       (slv_err[s])
    );

    // Slave-side mux: owner's request only while in REQ, zero otherwise.
    assign s_req_o[s]                     = in_req[s];
    assign s_cmd_o[s]                     = in_req[s] & own_cmd[s];
    assign s_addr_o[s*ADDR_W +: ADDR_W]   = in_req[s] ? m_addr_i[32'(owner[s])*ADDR_W +: ADDR_W] : '0;
    assign s_wdata_o[s*DATA_W +: DATA_W]  = in_req[s] ? m_wdata_i[32'(owner[s])*DATA_W +: DATA_W] : '0;
  end

  // Return paths: each slave reports only to its current owner.
  always_comb begin
    m_ack_o   = '0;
    m_resp_o  = '0;
    m_rdata_o = '0;
    m_err_o   = '0;
    for (int unsigned s = 0; s < N_SLV; s++) begin
      if (in_req[s] && s_ack_i[s]) begin
        m_ack_o[owner[s]] = 1'b1;
      end
      if ((in_resp[s] && s_resp_i[s]) ||
          (in_req[s] && s_ack_i[s] && s_resp_i[s] && !own_cmd[s])) begin
        m_resp_o[owner[s]] = 1'b1;
        m_rdata_o[32'(owner[s])*DATA_W +: DATA_W] = s_rdata_i[s*DATA_W +: DATA_W];
      end
      if (slv_err[s]) begin
        m_err_o[owner[s]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cross_bar_nxm.sv
// Directed self-checking bench for the 4x4 crossbar with an 8-cycle watchdog.
module tb_cross_bar_nxm;

  logic         clk;
  logic         rst_n;
  logic [3:0]   m_req, m_cmd, m_ack, m_resp, m_err;
  logic [127:0] m_addr, m_wdata, m_rdata;
  logic [3:0]   s_req, s_cmd, s_ack, s_resp;
  logic [127:0] s_addr, s_wdata, s_rdata;

  int checks;
  int errors;

  cross_bar_nxm #(
    .N_MST(4), .N_SLV(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_req_i   (m_req),
    .m_addr_i  (m_addr),
    .m_cmd_i   (m_cmd),
    .m_wdata_i (m_wdata),
    .m_ack_o   (m_ack),
    .m_resp_o  (m_resp),
    .m_rdata_o (m_rdata),
    .m_err_o   (m_err),
    .s_req_o   (s_req),
    .s_addr_o  (s_addr),
    .s_cmd_o   (s_cmd),
    .s_wdata_o (s_wdata),
    .s_ack_i   (s_ack),
    .s_resp_i  (s_resp),
    .s_rdata_i (s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic [31:0] addr, input logic cmd, input logic [31:0] wd);
    m_addr[m*32 +: 32]  = addr;
    m_cmd[m]            = cmd;
    m_wdata[m*32 +: 32] = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = '0; s_resp = '0; s_rdata = '0;
    repeat (3) sample();
    checks++;
    if ({m_ack, m_resp, m_err, s_req, s_cmd} !== 20'h0)
      begin errors++; $display("FAIL reset_ctrl: got %h expected 0", {m_ack, m_resp, m_err, s_req, s_cmd}); end
    checks++;
    if ({m_rdata, s_addr, s_wdata} !== 384'h0)
      begin errors++; $display("FAIL reset_data: got nonzero data buses, expected 0"); end
    rst_n = 1'b1;
    sample();
    checks++;
    if (s_req !== 4'b0000) begin errors++; $display("FAIL idle_s_req: got %b expected 0000", s_req); end
  endtask

  task automatic test_read_single();
    tick(); set_m(0, 32'h4000_0010, 1'b0, 32'h0); m_req[0] = 1'b1;
    sample();
    checks++;
    if (s_req !== 4'b0000) begin errors++; $display("FAIL t1_latency: got %b expected 0000", s_req); end
    tick(); s_ack[1] = 1'b1;
    sample();
    checks++;
    if (s_req !== 4'b0010) begin errors++; $display("FAIL t1_s_req: got %b expected 0010", s_req); end
    checks++;
    if (s_addr[63:32] !== 32'h4000_0010) begin errors++; $display("FAIL t1_s_addr: got %h expected 40000010", s_addr[63:32]); end
    checks++;
    if (m_ack !== 4'b0001) begin errors++; $display("FAIL t1_m_ack: got %b expected 0001", m_ack); end
    tick(); s_ack[1] = 1'b0; m_req[0] = 1'b0;
    sample();
    checks++;
    if ({s_req, m_ack, m_resp} !== 12'h0) begin errors++; $display("FAIL t1_resp_wait: got %h expected 000", {s_req, m_ack, m_resp}); end
    tick(); tick(); s_resp[1] = 1'b1; s_rdata[63:32] = 32'hDEAD_BEEF;
    sample();
    checks++;
    if (m_resp !== 4'b0001) begin errors++; $display("FAIL t1_m_resp: got %b expected 0001", m_resp); end
    checks++;
    if (m_rdata[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_m_rdata: got %h expected deadbeef", m_rdata[31:0]); end
    tick(); s_resp[1] = 1'b0; s_rdata = '0;
    sample();
    checks++;
    if (m_resp !== 4'b0000) begin errors++; $display("FAIL t1_resp_pulse: got %b expected 0000", m_resp); end
  endtask

  task automatic test_rr_write();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    tick();
    for (int m = 0; m < 4; m++) set_m(m, 32'h8000_0000 | 32'(m << 4), 1'b1, 32'hA0 + 32'(m));
    m_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(); s_ack[2] = 1'b1;
      sample();
      checks++;
      if (m_ack !== (4'b0001 << order[k]))
        begin errors++; $display("FAIL t2_grant_%0d: got %b expected %b", k, m_ack, 4'b0001 << order[k]); end
      checks++;
      if (s_wdata[95:64] !== 32'hA0 + 32'(order[k]) || s_cmd !== 4'b0100)
        begin errors++; $display("FAIL t2_wdata_%0d: got %h/%b expected %h/0100", k, s_wdata[95:64], s_cmd, 32'hA0 + 32'(order[k])); end
      tick(); s_ack[2] = 1'b0; m_req[order[k]] = 1'b0;
      if (k == 1) m_req[0] = 1'b1;
      sample();
      checks++;
      if (s_req !== 4'b0000) begin errors++; $display("FAIL t2_idle_%0d: got %b expected 0000", k, s_req); end
    end
  endtask

  task automatic test_parallel();
    tick();
    set_m(0, 32'h0000_0100, 1'b1, 32'h1111_0000);
    set_m(1, 32'hC000_0200, 1'b1, 32'h2222_0000);
    m_req = 4'b0011;
    sample();
    checks++;
    if (s_req !== 4'b0000) begin errors++; $display("FAIL t3_latency: got %b expected 0000", s_req); end
    tick(); s_ack[0] = 1'b1;
    sample();
    checks++;
    if (s_req !== 4'b1001) begin errors++; $display("FAIL t3_both_req: got %b expected 1001", s_req); end
    checks++;
    if (m_ack !== 4'b0001 || s_wdata[31:0] !== 32'h1111_0000)
      begin errors++; $display("FAIL t3_ack0: got %b/%h expected 0001/11110000", m_ack, s_wdata[31:0]); end
    tick(); s_ack[0] = 1'b0; m_req[0] = 1'b0;
    sample();
    checks++;
    if (s_req !== 4'b1000 || m_ack !== 4'b0000) begin errors++; $display("FAIL t3_indep: got %b/%b expected 1000/0000", s_req, m_ack); end
    tick(); s_ack[3] = 1'b1;
    sample();
    checks++;
    if (m_ack !== 4'b0010 || s_addr[127:96] !== 32'hC000_0200)
      begin errors++; $display("FAIL t3_ack3: got %b/%h expected 0010/c0000200", m_ack, s_addr[127:96]); end
    tick(); s_ack[3] = 1'b0; m_req[1] = 1'b0;
    sample();
    checks++;
    if (s_req !== 4'b0000) begin errors++; $display("FAIL t3_done: got %b expected 0000", s_req); end
  endtask

  task automatic test_timeout();
    tick();
    set_m(2, 32'h4000_0020, 1'b0, 32'h0);
    set_m(3, 32'h4000_0030, 1'b1, 32'h0000_CAFE);
    m_req = 4'b1100;
    tick();
    sample();
    checks++;
    if (s_req !== 4'b0010 || s_addr[63:32] !== 32'h4000_0020)
      begin errors++; $display("FAIL t4_grant_m2: got %b/%h expected 0010/40000020", s_req, s_addr[63:32]); end
    for (int i = 2; i <= 8; i++) begin
      tick();
      sample();
      checks++;
      if (s_req !== 4'b0010 || m_err !== 4'b0000)
        begin errors++; $display("FAIL t4_wait_%0d: got %b/%b expected 0010/0000", i, s_req, m_err); end
    end
    tick(); m_req[2] = 1'b0;
    sample();
    checks++;
    if (m_err !== 4'b0100) begin errors++; $display("FAIL t4_m_err: got %b expected 0100", m_err); end
    checks++;
    if (s_req !== 4'b0000) begin errors++; $display("FAIL t4_s_req_drop: got %b expected 0000", s_req); end
    tick(); s_ack[1] = 1'b1;
    sample();
    checks++;
    if (m_ack !== 4'b1000 || s_addr[63:32] !== 32'h4000_0030 || m_err !== 4'b0000)
      begin errors++; $display("FAIL t4_next_m3: got %b/%h/%b expected 1000/40000030/0000", m_ack, s_addr[63:32], m_err); end
    tick(); s_ack[1] = 1'b0; m_req[3] = 1'b0;
    sample();
  endtask

  task automatic test_ack_resp_same();
    tick(); set_m(2, 32'hC000_0000, 1'b0, 32'h0); m_req[2] = 1'b1;
    tick(); s_ack[3] = 1'b1; s_resp[3] = 1'b1; s_rdata[127:96] = 32'h1234_5678;
    sample();
    checks++;
    if (m_ack !== 4'b0100 || m_resp !== 4'b0100)
      begin errors++; $display("FAIL t6_ack_resp: got %b/%b expected 0100/0100", m_ack, m_resp); end
    checks++;
    if (m_rdata[95:64] !== 32'h1234_5678) begin errors++; $display("FAIL t6_rdata: got %h expected 12345678", m_rdata[95:64]); end
    tick(); s_ack[3] = 1'b0; m_req[2] = 1'b0;
    sample();
    checks++;
    if (m_resp !== 4'b0000 || s_req !== 4'b0000)
      begin errors++; $display("FAIL t6_stray_resp: got %b/%b expected 0000/0000", m_resp, s_req); end
    tick(); s_resp = '0; s_rdata = '0;
  endtask

  task automatic test_reset_mid();
    tick(); set_m(1, 32'h0000_0040, 1'b0, 32'h0); m_req[1] = 1'b1;
    tick(); s_ack[0] = 1'b1;
    sample();
    checks++;
    if (m_ack !== 4'b0010) begin errors++; $display("FAIL t5_pre_ack: got %b expected 0010", m_ack); end
    tick(); s_ack[0] = 1'b0; m_req[1] = 1'b0;
    #2; rst_n = 1'b0; s_resp[0] = 1'b1; s_rdata[31:0] = 32'h55AA_55AA;
    #1;
    checks++;
    if ({m_ack, m_resp, m_err, s_req} !== 16'h0) begin errors++; $display("FAIL t5_async_ctrl: got %h expected 0000", {m_ack, m_resp, m_err, s_req}); end
    checks++;
    if (m_rdata !== 128'h0) begin errors++; $display("FAIL t5_async_rdata: got %h expected 0", m_rdata); end
    sample(); rst_n = 1'b1; s_resp = '0; s_rdata = '0;
    tick();
    set_m(0, 32'h0000_0080, 1'b1, 32'h0000_1111);
    set_m(1, 32'h0000_00C0, 1'b1, 32'h0000_2222);
    m_req = 4'b0011;
    tick(); s_ack[0] = 1'b1;
    sample();
    checks++;
    if (m_ack !== 4'b0001 || s_addr[31:0] !== 32'h0000_0080)
      begin errors++; $display("FAIL t5_ptr0: got %b/%h expected 0001/00000080", m_ack, s_addr[31:0]); end
    tick(); s_ack[0] = 1'b0; m_req[0] = 1'b0;
    sample();
    checks++;
    if (m_err !== 4'b0000 || m_ack !== 4'b0000) begin errors++; $display("FAIL t5_no_err: got %b/%b expected 0000/0000", m_err, m_ack); end
    tick(); s_ack[0] = 1'b1;
    sample();
    checks++;
    if (m_ack !== 4'b0010 || s_wdata[31:0] !== 32'h0000_2222)
      begin errors++; $display("FAIL t5_next_m1: got %b/%h expected 0010/00002222", m_ack, s_wdata[31:0]); end
    tick(); s_ack = '0; m_req = '0;
    sample();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read_single();
    test_rr_write();
    test_parallel();
    test_timeout();
    test_ack_resp_same();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
